// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation and state
// encodings plus the operation-class decode used by the FSM.
// Optional build macro: MDU_MADD_EN enables the madd/maddu/msub/msubu ops.
package mult_div_unit_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    MDU_OP_MULT  = 3'b000,
    MDU_OP_MULTU = 3'b001,
    MDU_OP_DIV   = 3'b010,
    MDU_OP_DIVU  = 3'b011,
    MDU_OP_MADD  = 3'b100,
    MDU_OP_MADDU = 3'b101,
    MDU_OP_MSUB  = 3'b110,
    MDU_OP_MSUBU = 3'b111
  } mduOp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10
  } mduState_e;

  // Multiply-class ops share the MUL latency; the accumulate family only
  // exists when the accumulate datapath is built.
  function automatic logic isMulOp(input logic [2:0] op);
`ifdef MDU_MADD_EN
    return (op != MDU_OP_DIV) && (op != MDU_OP_DIVU);
`else
    return (op == MDU_OP_MULT) || (op == MDU_OP_MULTU);
`endif
  endfunction

  function automatic logic isDivOp(input logic [2:0] op);
    return (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Start/Busy/HI/LO link between the execute stage (master) and the
// multiply/divide unit (slave).
// Optional build macro: MDU_MADD_EN (widens the meaning of Op, not the bus).
interface mult_div_unit_if;
  import mult_div_unit_pkg::*;

  logic [DATA_W-1:0] D1;
  logic [DATA_W-1:0] D2;
  logic [2:0]        Op;
  logic              Start;
  logic              We;
  logic              HiLo;
  logic              Busy;
  logic [DATA_W-1:0] HI;
  logic [DATA_W-1:0] LO;

  modport master (
    output D1, D2, Op, Start, We, HiLo,
    input  Busy, HI, LO
  );

  modport slave (
    input  D1, D2, Op, Start, We, HiLo,
    output Busy, HI, LO
  );

endinterface

// File: rtl/mdu_arith.sv
// Combinational arithmetic core of the multiply/divide unit. Produces the
// 64-bit {HI,LO} candidate for the requested op and flags divide-by-zero.
// Optional build macro: MDU_MADD_EN adds the accumulate input and the
// madd/maddu/msub/msubu results.
module mdu_arith
  import mult_div_unit_pkg::*;
(
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic [2:0]          op,
`ifdef MDU_MADD_EN
  input  logic [2*DATA_W-1:0] acc,
`endif
  output logic [2*DATA_W-1:0] result,
  output logic                divByZero
);

  function automatic logic signed [2*DATA_W-1:0] signExt(input logic [DATA_W-1:0] v);
    return $signed({{DATA_W{v[DATA_W-1]}}, v});
  endfunction

  logic signed [2*DATA_W-1:0] sProd;
  logic        [2*DATA_W-1:0] uProd;
  logic signed [2*DATA_W-1:0] sDividend;
  logic signed [2*DATA_W-1:0] sDivisor;
  logic        [DATA_W-1:0]   uDivisor;
  logic        [DATA_W-1:0]   sQuot;
  logic        [DATA_W-1:0]   sRem;
  logic        [DATA_W-1:0]   uQuot;
  logic        [DATA_W-1:0]   uRem;

  assign divByZero = (b == '0);

  // Both products are formed at full 64-bit width so the signed one keeps
  // correct upper bits.
  assign sProd = signExt(a) * signExt(b);
  assign uProd = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

  // Division runs at 64 bits so 0x80000000 / -1 yields 0x80000000 without
  // overflow; a zero divisor is replaced by 1 since its result is discarded.
  assign sDividend = signExt(a);
  assign sDivisor  = divByZero ? 64'sd1 : signExt(b);
  assign uDivisor  = divByZero ? {{(DATA_W-1){1'b0}}, 1'b1} : b;
  assign sQuot     = DATA_W'(sDividend / sDivisor);
  assign sRem      = DATA_W'(sDividend % sDivisor);
  assign uQuot     = a / uDivisor;
  assign uRem      = a % uDivisor;

  // Select the {HI,LO} image for the requested operation.
  always_comb begin
    result = '0;
    case (op)
      MDU_OP_MULT:  result = sProd;
      MDU_OP_MULTU: result = uProd;
      MDU_OP_DIV:   result = {sRem, sQuot};
      MDU_OP_DIVU:  result = {uRem, uQuot};
`ifdef MDU_MADD_EN
      MDU_OP_MADD:  result = acc + sProd;
      MDU_OP_MADDU: result = acc + uProd;
      MDU_OP_MSUB:  result = acc - sProd;
      MDU_OP_MSUBU: result = acc - uProd;
`endif
      default:      result = '0;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit. Captures one operation on Start, holds
// Busy for a fixed latency, then commits the result into HI/LO.
// Optional build macro: MDU_MADD_EN enables madd/maddu/msub/msubu, which
// accumulate onto {HI,LO} as sampled at Start.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic            clk,
  input logic            rst,
  mult_div_unit_if.slave mdu
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  mduState_e                state;
  mduState_e                stateNext;
  logic [CNT_W-1:0]         cnt;
  logic [CNT_W-1:0]         cntNext;
  logic                     capture;
  logic                     commit;
  logic                     weApply;

  logic [DATA_W-1:0]        hiReg;
  logic [DATA_W-1:0]        loReg;
  logic [2*DATA_W-1:0]      pendRes;
  logic                     pendWr;
  logic [2*DATA_W-1:0]      arithRes;
  logic                     arithDivZero;

  mdu_arith uArith (
    .a         (mdu.D1),
    .b         (mdu.D2),
    .op        (mdu.Op),
`ifdef MDU_MADD_EN
    .acc       ({hiReg, loReg}),
`endif
    .result    (arithRes),
    .divByZero (arithDivZero)
  );

  // State and latency counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Next-state, counter load/decrement and the capture/commit/write strobes.
  // Start takes priority over We in IDLE; both are ignored while busy.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    capture   = 1'b0;
    commit    = 1'b0;
    weApply   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mdu.Start) begin
          if (isMulOp(mdu.Op)) begin
            stateNext = ST_MUL;
            cntNext   = CNT_W'(MUL_CYCLES);
            capture   = 1'b1;
          end else if (isDivOp(mdu.Op)) begin
            stateNext = ST_DIV;
            cntNext   = CNT_W'(DIV_CYCLES);
            capture   = 1'b1;
          end
        end else if (mdu.We) begin
          weApply = 1'b1;
        end
      end
      ST_MUL, ST_DIV: begin
        cntNext = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          stateNext = ST_IDLE;
          commit    = 1'b1;
        end
      end
      default: begin
        stateNext = ST_IDLE;
        cntNext   = '0;
      end
    endcase
  end

  // Pending result captured at Start; a divide by zero suppresses the commit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pendWr <= 1'b0;
    end else if (capture) begin
      pendWr <= !(isDivOp(mdu.Op) && arithDivZero);
    end
  end

  // Pending data needs no reset: it is only consumed after a capture.
  always_ff @(posedge clk) begin
    if (capture) begin
      pendRes <= arithRes;
    end
  end

  // Architectural HI/LO: commit at end of latency, or direct write from We.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hiReg <= '0;
      loReg <= '0;
    end else if (commit) begin
      if (pendWr) begin
        hiReg <= pendRes[2*DATA_W-1:DATA_W];
        loReg <= pendRes[DATA_W-1:0];
      end
    end else if (weApply) begin
      if (mdu.HiLo) begin
        hiReg <= mdu.D1;
      end else begin
        loReg <= mdu.D1;
      end
    end
  end

  assign mdu.Busy = (state != ST_IDLE);
  assign mdu.HI   = hiReg;
  assign mdu.LO   = loReg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit with hand-computed expectations.
// Optional build macro: MDU_MADD_EN switches the Op[2] test from
// "ignored" to the madd accumulate case.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checkCnt = 0;
  int   passCnt  = 0;

  mult_div_unit_if mdu ();

  mult_div_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk (clk),
    .rst (rst),
    .mdu (mdu)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCnt++;
    if (obs === exp) passCnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Issue one op, then count Busy cycles until it drops (bounded).
  task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int busyCycles);
    int guard;
    @(negedge clk);
    mdu.Op = op; mdu.D1 = a; mdu.D2 = b; mdu.Start = 1'b1;
    @(negedge clk);
    mdu.Start = 1'b0;
    busyCycles = 0;
    guard = 0;
    while (mdu.Busy && guard < 40) begin
      busyCycles++;
      guard++;
      @(negedge clk);
    end
  endtask

  task automatic writeReg(input logic hiSel, input logic [31:0] val);
    @(negedge clk);
    mdu.We = 1'b1; mdu.HiLo = hiSel; mdu.D1 = val;
    @(negedge clk);
    mdu.We = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bc;
    int guard;
    mdu.D1 = '0; mdu.D2 = '0; mdu.Op = '0;
    mdu.Start = 1'b0; mdu.We = 1'b0; mdu.HiLo = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    checkVal("rst_busy", 64'(mdu.Busy), 64'd0);
    checkVal("rst_hi", 64'(mdu.HI), 64'd0);
    checkVal("rst_lo", 64'(mdu.LO), 64'd0);
    rst = 1'b1;

    // mult -3 * 5
    runOp(MDU_OP_MULT, 32'hFFFF_FFFD, 32'd5, bc);
    checkVal("mult_busy", 64'(bc), 64'd5);
    checkVal("mult_hi", 64'(mdu.HI), 64'hFFFF_FFFF);
    checkVal("mult_lo", 64'(mdu.LO), 64'hFFFF_FFF1);

    // multu max * max
    runOp(MDU_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc);
    checkVal("multu_hilo", {mdu.HI, mdu.LO}, 64'hFFFF_FFFE_0000_0001);

    // divu 7 / 2
    runOp(MDU_OP_DIVU, 32'd7, 32'd2, bc);
    checkVal("divu_busy", 64'(bc), 64'd10);
    checkVal("divu_lo", 64'(mdu.LO), 64'd3);
    checkVal("divu_hi", 64'(mdu.HI), 64'd1);

    // div -7 / 2
    runOp(MDU_OP_DIV, 32'hFFFF_FFF9, 32'd2, bc);
    checkVal("div_neg_lo", 64'(mdu.LO), 64'hFFFF_FFFD);
    checkVal("div_neg_hi", 64'(mdu.HI), 64'hFFFF_FFFF);

    // div overflow corner
    runOp(MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, bc);
    checkVal("div_ovf_lo", 64'(mdu.LO), 64'h8000_0000);
    checkVal("div_ovf_hi", 64'(mdu.HI), 64'd0);

    // divide by zero keeps preloaded HI/LO
    writeReg(1'b1, 32'h11);
    checkVal("we_hi_busy", 64'(mdu.Busy), 64'd0);
    writeReg(1'b0, 32'h22);
    runOp(MDU_OP_DIV, 32'd5, 32'd0, bc);
    checkVal("div0_busy", 64'(bc), 64'd10);
    checkVal("div0_hilo", {mdu.HI, mdu.LO}, 64'h0000_0011_0000_0022);

    // direct HI write
    writeReg(1'b1, 32'hABCD);
    checkVal("we_hi", 64'(mdu.HI), 64'hABCD);
    checkVal("we_busy", 64'(mdu.Busy), 64'd0);
    checkVal("we_lo_keep", 64'(mdu.LO), 64'h22);

    // Start + We together: Start wins
    @(negedge clk);
    mdu.Op = MDU_OP_MULT; mdu.D1 = 32'd2; mdu.D2 = 32'd3;
    mdu.Start = 1'b1; mdu.We = 1'b1; mdu.HiLo = 1'b1;
    @(negedge clk);
    mdu.Start = 1'b0; mdu.We = 1'b0;
    checkVal("startwe_hi_early", 64'(mdu.HI), 64'hABCD);
    guard = 0;
    while (mdu.Busy && guard < 40) begin guard++; @(negedge clk); end
    checkVal("startwe_hilo", {mdu.HI, mdu.LO}, 64'd6);

    // Start multu and We while divu is busy: ignored
    @(negedge clk);
    mdu.Op = MDU_OP_DIVU; mdu.D1 = 32'd100; mdu.D2 = 32'd7; mdu.Start = 1'b1;
    @(negedge clk);
    mdu.Start = 1'b0;
    bc = 0;
    guard = 0;
    while (mdu.Busy && guard < 40) begin
      bc++;
      guard++;
      if (bc == 3) begin
        mdu.Op = MDU_OP_MULTU; mdu.D1 = 32'd3; mdu.D2 = 32'd3;
        mdu.Start = 1'b1; mdu.We = 1'b1; mdu.HiLo = 1'b0;
      end else begin
        mdu.Start = 1'b0; mdu.We = 1'b0;
      end
      @(negedge clk);
    end
    mdu.Start = 1'b0; mdu.We = 1'b0;
    checkVal("busy_ign_cycles", 64'(bc), 64'd10);
    checkVal("busy_ign_hilo", {mdu.HI, mdu.LO}, {32'd2, 32'd14});
    @(negedge clk);
    checkVal("busy_ign_idle", 64'(mdu.Busy), 64'd0);

`ifdef MDU_MADD_EN
    // madd accumulates onto HI/LO
    writeReg(1'b1, 32'd0);
    writeReg(1'b0, 32'd10);
    runOp(MDU_OP_MADD, 32'd3, 32'd4, bc);
    checkVal("madd_busy", 64'(bc), 64'd5);
    checkVal("madd_hilo", {mdu.HI, mdu.LO}, 64'd22);
`else
    // Op[2]=1 without the accumulate build: Start ignored
    @(negedge clk);
    mdu.Op = MDU_OP_MADD; mdu.D1 = 32'd3; mdu.D2 = 32'd4; mdu.Start = 1'b1;
    @(negedge clk);
    mdu.Start = 1'b0;
    checkVal("undef_busy", 64'(mdu.Busy), 64'd0);
    checkVal("undef_hilo", {mdu.HI, mdu.LO}, {32'd2, 32'd14});
`endif

    // Reset in cycle 4 of a div aborts without commit
    writeReg(1'b1, 32'h55);
    @(negedge clk);
    mdu.Op = MDU_OP_DIVU; mdu.D1 = 32'd9; mdu.D2 = 32'd2; mdu.Start = 1'b1;
    @(negedge clk);
    mdu.Start = 1'b0;
    repeat (3) @(negedge clk);
    checkVal("rstmid_busy_pre", 64'(mdu.Busy), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checkVal("rstmid_busy", 64'(mdu.Busy), 64'd0);
    checkVal("rstmid_hilo", {mdu.HI, mdu.LO}, 64'd0);
    repeat (12) @(negedge clk);
    checkVal("rstmid_nolate", {mdu.HI, mdu.LO}, 64'd0);
    checkVal("rstmid_idle", 64'(mdu.Busy), 64'd0);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
